mvm_ctrl: RTL and testbench

Control sequencer for the matrix-vector multiply unit. It decodes the one-cycle `loadMatrix`, `loadVector` and `start` command pulses and generates all write/read addresses and enables for the matrix memory, vector memory, MAC accumulator and output buffer. It also times the `done` pulse and the output stream. It contains no datapath arithmetic: the MAC, memories and output register sit in the surrounding MVM top level and are driven only by this block.

---
 rtl/mvm_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mvm_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_ctrl.sv
// Control sequencer for the matrix-vector multiply unit: decodes load/start
// pulses and drives every memory, MAC and output-buffer address and enable.
module mvm_ctrl #(
  parameter int M    = 20,
  parameter int PIPE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      loadMatrix,
  input  logic                      loadVector,
  input  logic                      start,
  output logic                      mat_we,
  output logic [$clog2(M*M)-1:0]    mat_addr,
  output logic                      vec_we,
  output logic [$clog2(M)-1:0]      vec_addr,
  output logic                      mac_en,
  output logic                      acc_clr,
  output logic                      ybuf_we,
  output logic [$clog2(M)-1:0]      ybuf_addr,
  output logic                      out_valid,
  output logic                      done,
  output logic                      busy
);

  localparam int LAT = 1 + PIPE;
  localparam int MM  = M * M;
  localparam int MW  = $clog2(MM);
  localparam int VW  = $clog2(M);

  localparam logic [MW-1:0] MAT_LAST   = MW'(MM - 1);
  localparam logic [VW-1:0] VEC_LAST   = VW'(M - 1);
  localparam logic [1:0]    DRAIN_LAST = 2'(LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_M,
    S_LOAD_V,
    S_COMPUTE,
    S_DRAIN,
    S_OUTPUT
  } state_t;

  state_t         state;
  logic [VW-1:0]  row;
  logic [1:0]     drain_cnt;

  // Per-issue tags delayed by LAT cycles so they line up with the product.
  logic [LAT-1:0] vld_sr;
  logic [LAT-1:0] clr_sr;
  logic [LAT-1:0] last_sr;
  logic [VW-1:0]  row_sr [LAT];

  logic issue;
  logic col_first;
  logic col_last;

  assign issue     = (state == S_COMPUTE);
  assign col_first = (vec_addr == '0);
  assign col_last  = (vec_addr == VEC_LAST);

  assign mac_en  = vld_sr[LAT-1];
  assign acc_clr = clr_sr[LAT-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      row       <= '0;
      drain_cnt <= '0;
      mat_we    <= 1'b0;
      mat_addr  <= '0;
      vec_we    <= 1'b0;
      vec_addr  <= '0;
      ybuf_we   <= 1'b0;
      ybuf_addr <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      vld_sr    <= '0;
      clr_sr    <= '0;
      last_sr   <= '0;
      // NOTE: the row delay line is reset along with the enables so a reset
      // mid-compute leaves nothing in flight; it is tiny, unlike a RAM.
      for (int i = 0; i < LAT; i++) row_sr[i] <= '0;
    end else begin
      vld_sr[0]  <= issue;
      clr_sr[0]  <= issue && col_first;
      last_sr[0] <= issue && col_last;
      row_sr[0]  <= row;
      for (int i = 1; i < LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        clr_sr[i]  <= clr_sr[i-1];
        last_sr[i] <= last_sr[i-1];
        row_sr[i]  <= row_sr[i-1];
      end

      // Row result is captured the cycle after its final accumulate.
      ybuf_we <= last_sr[LAT-1];
      if (last_sr[LAT-1]) ybuf_addr <= row_sr[LAT-1];

      out_valid <= (state == S_OUTPUT);
      // NOTE: non-blocking default here; a later assignment to the same
      // register in this block (the DRAIN exit) wins for this edge.
      done      <= 1'b0;

      case (state)
        S_IDLE: begin
          if (loadMatrix) begin
            state    <= S_LOAD_M;
            mat_we   <= 1'b1;
            mat_addr <= '0;
            busy     <= 1'b1;
          end else if (loadVector) begin
            state    <= S_LOAD_V;
            vec_we   <= 1'b1;
            vec_addr <= '0;
            busy     <= 1'b1;
          end else if (start) begin
            state    <= S_COMPUTE;
            mat_addr <= '0;
            vec_addr <= '0;
            row      <= '0;
            busy     <= 1'b1;
          end
        end

        S_LOAD_M: begin
          if (mat_addr == MAT_LAST) begin
            state  <= S_IDLE;
            mat_we <= 1'b0;
            busy   <= 1'b0;
          end else begin
            mat_addr <= mat_addr + MW'(1);
          end
        end

        S_LOAD_V: begin
          if (vec_addr == VEC_LAST) begin
            state  <= S_IDLE;
            vec_we <= 1'b0;
            busy   <= 1'b0;
          end else begin
            vec_addr <= vec_addr + VW'(1);
          end
        end

        S_COMPUTE: begin
          mat_addr <= (mat_addr == MAT_LAST) ? '0 : mat_addr + MW'(1);
          if (col_last) begin
            vec_addr <= '0;
            if (row == VEC_LAST) begin
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end else begin
              row <= row + VW'(1);
            end
          end else begin
            vec_addr <= vec_addr + VW'(1);
          end
        end

        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state     <= S_OUTPUT;
            ybuf_addr <= '0;
            done      <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end

        S_OUTPUT: begin
          if (ybuf_addr == VEC_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            ybuf_addr <= ybuf_addr + VW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_ctrl.sv
// Bench for mvm_ctrl: PIPE=0 and PIPE=1 builds side by side, scored every
// cycle against a timeline model derived from command acceptance times.
module tb_mvm_ctrl;

  localparam int M  = 20;
  localparam int MM = M * M;
  localparam int MW = $clog2(MM);
  localparam int VW = $clog2(M);
  localparam int BW = MW + 2 * VW + 8;
  localparam int NEVER = -100000;

  typedef enum int {OP_NONE, OP_LM, OP_LV, OP_CP} op_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic loadMatrix = 1'b0;
  logic loadVector = 1'b0;
  logic start = 1'b0;

  // Index 0 is the PIPE=0 build, index 1 the PIPE=1 build (LAT = 1 + index).
  logic          mat_we    [2];
  logic [MW-1:0] mat_addr  [2];
  logic          vec_we    [2];
  logic [VW-1:0] vec_addr  [2];
  logic          mac_en    [2];
  logic          acc_clr   [2];
  logic          ybuf_we   [2];
  logic [VW-1:0] ybuf_addr [2];
  logic          out_valid [2];
  logic          done      [2];
  logic          busy      [2];

  mvm_ctrl #(.M(M), .PIPE(0)) u_pipe0 (
    .clk(clk), .reset(reset),
    .loadMatrix(loadMatrix), .loadVector(loadVector), .start(start),
    .mat_we(mat_we[0]), .mat_addr(mat_addr[0]),
    .vec_we(vec_we[0]), .vec_addr(vec_addr[0]),
    .mac_en(mac_en[0]), .acc_clr(acc_clr[0]),
    .ybuf_we(ybuf_we[0]), .ybuf_addr(ybuf_addr[0]),
    .out_valid(out_valid[0]), .done(done[0]), .busy(busy[0])
  );

  mvm_ctrl #(.M(M), .PIPE(1)) u_pipe1 (
    .clk(clk), .reset(reset),
    .loadMatrix(loadMatrix), .loadVector(loadVector), .start(start),
    .mat_we(mat_we[1]), .mat_addr(mat_addr[1]),
    .vec_we(vec_we[1]), .vec_addr(vec_addr[1]),
    .mac_en(mac_en[1]), .acc_clr(acc_clr[1]),
    .ybuf_we(ybuf_we[1]), .ybuf_addr(ybuf_addr[1]),
    .out_valid(out_valid[1]), .done(done[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: what each build is doing and since which command cycle.
  op_t op    [2];
  int  t0    [2];
  int  lastc [2];

  int checks = 0;
  int errors = 0;
  int mac_cnt [2];
  int ybw_cnt [2];
  int done_cnt [2];
  int done_cyc [2];
  int matwe_cnt [2];
  int vecwe_cnt [2];
  int drive_cyc;

  function automatic logic [BW-1:0] obs_of(input int i);
    return {mat_we[i], mat_addr[i], vec_we[i], vec_addr[i], mac_en[i], acc_clr[i],
            ybuf_we[i], ybuf_addr[i], out_valid[i], done[i], busy[i]};
  endfunction

  function automatic int op_len(input int i);
    case (op[i])
      OP_LM:   return MM + 1;
      OP_LV:   return M + 1;
      OP_CP:   return MM + (1 + i) + 2 + M;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_idle(input int i, input int n);
    return (op[i] == OP_NONE) || (n - t0[i] >= op_len(i));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      op[i]    = OP_NONE;
      t0[i]    = 0;
      lastc[i] = NEVER;
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      mac_cnt[i] = 0; ybw_cnt[i] = 0; done_cnt[i] = 0; done_cyc[i] = -1;
      matwe_cnt[i] = 0; vecwe_cnt[i] = 0;
    end
  endtask

  // Expected outputs of build i in cycle n, with a mask of the fields that matter.
  task automatic model_expect(input int i, input int n,
                              output logic [BW-1:0] e, output logic [BW-1:0] m);
    int L, k, ia, ib, o, vo;
    logic mw, vw, me, ac, yw, ov, dn, bz, mam, vam, yam;
    logic [MW-1:0] ma;
    logic [VW-1:0] va, ya;
    {mw, vw, me, ac, yw, ov, dn, bz, mam, vam, yam} = '0;
    ma = '0; va = '0; ya = '0;
    L = 1 + i;
    k = n - t0[i];
    case (op[i])
      OP_LM: if (k >= 1 && k <= MM) begin
        mw = 1'b1; bz = 1'b1; ma = MW'(k - 1); mam = 1'b1;
      end
      OP_LV: if (k >= 1 && k <= M) begin
        vw = 1'b1; bz = 1'b1; va = VW'(k - 1); vam = 1'b1;
      end
      OP_CP: begin
        bz = (k >= 1 && k <= MM + L + 1 + M);
        if (k >= 1 && k <= MM) begin
          ma = MW'(k - 1); mam = 1'b1;
          va = VW'((k - 1) % M); vam = 1'b1;
        end
        ia = k - 1 - L;
        if (ia >= 0 && ia < MM) begin
          me = 1'b1; ac = (ia % M == 0);
        end
        ib = k - 2 - L;
        if (ib >= 0 && ib < MM && ib % M == M - 1) begin
          yw = 1'b1; ya = VW'(ib / M); yam = 1'b1;
        end
        o = k - (MM + L + 2);
        if (o >= 0 && o < M) begin
          ya = VW'(o); yam = 1'b1; dn = (o == 0);
        end
      end
      default: ;
    endcase
    vo = n - lastc[i] - (MM + L + 3);
    ov = (vo >= 0 && vo < M);
    e = {mw, ma, vw, va, me, ac, yw, ya, ov, dn, bz};
    m = {1'b1, {MW{mam}}, 1'b1, {VW{vam}}, 3'b111, {VW{yam}}, 3'b111};
  endtask

  // One cycle: score both builds, then drive this cycle's command inputs.
  task automatic tick(input logic lm, input logic lv, input logic st);
    logic [BW-1:0] e, m, o;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      model_expect(i, cyc, e, m);
      o = obs_of(i);
      checks++;
      if ((o & m) !== (e & m)) begin
        errors++;
        $display("FAIL cycle_cmp PIPE%0d cyc=%0d got=%h expected=%h mask=%h", i, cyc, o, e, m);
      end
      if (mac_en[i])  mac_cnt[i]++;
      if (ybuf_we[i]) ybw_cnt[i]++;
      if (mat_we[i])  matwe_cnt[i]++;
      if (vec_we[i])  vecwe_cnt[i]++;
      if (done[i]) begin
        done_cnt[i]++;
        done_cyc[i] = cyc;
      end
    end
    drive_cyc  = cyc;
    loadMatrix = lm;
    loadVector = lv;
    start      = st;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (model_idle(i, cyc)) begin
          if (lm) begin
            op[i] = OP_LM; t0[i] = cyc;
          end else if (lv) begin
            op[i] = OP_LV; t0[i] = cyc;
          end else if (st) begin
            op[i] = OP_CP; t0[i] = cyc; lastc[i] = cyc;
          end
        end
      end
    end
  endtask

  task automatic idle_ticks(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_of(i) !== '0) begin
        errors++;
        $display("FAIL %s PIPE%0d got=%h expected=0", name, i, obs_of(i));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    clear_counts();
    idle_ticks(3);
    check_all_zero("reset_hold");
    reset = 1'b0;
    idle_ticks(2);
    tick(1'b1, 1'b0, 1'b0);
    idle_ticks(5);
    #2 reset = 1'b1;
    #1 check_all_zero("reset_async_load");
    model_reset();
    idle_ticks(2);
    reset = 1'b0;
    idle_ticks(2);
  endtask

  task automatic test_load();
    clear_counts();
    tick(1'b1, 1'b0, 1'b0);
    idle_ticks(MM);
    tick(1'b0, 1'b1, 1'b0);
    idle_ticks(M + 2);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (matwe_cnt[i] !== MM || vecwe_cnt[i] !== M) begin
        errors++;
        $display("FAIL load_counts PIPE%0d got mat_we=%0d vec_we=%0d expected %0d/%0d",
                 i, matwe_cnt[i], vecwe_cnt[i], MM, M);
      end
    end
  endtask

  task automatic test_compute();
    int ts;
    clear_counts();
    tick(1'b0, 1'b0, 1'b1);
    ts = drive_cyc;
    idle_ticks(MM + M + 10);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (done_cyc[i] - ts !== MM + (1 + i) + 2 || done_cnt[i] !== 1) begin
        errors++;
        $display("FAIL done_latency PIPE%0d got=%0d (count %0d) expected=%0d",
                 i, done_cyc[i] - ts, done_cnt[i], MM + (1 + i) + 2);
      end
      checks++;
      if (mac_cnt[i] !== MM || ybw_cnt[i] !== M) begin
        errors++;
        $display("FAIL compute_counts PIPE%0d got mac_en=%0d ybuf_we=%0d expected %0d/%0d",
                 i, mac_cnt[i], ybw_cnt[i], MM, M);
      end
    end
  endtask

  task automatic test_priority();
    clear_counts();
    tick(1'b1, 1'b0, 1'b1);
    idle_ticks(10);
    tick(1'b0, 1'b0, 1'b1);
    idle_ticks(MM);
    tick(1'b0, 1'b1, 1'b1);
    idle_ticks(M + 3);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (mac_cnt[i] !== 0 || done_cnt[i] !== 0 || vecwe_cnt[i] !== M) begin
        errors++;
        $display("FAIL priority PIPE%0d got mac_en=%0d done=%0d vec_we=%0d expected 0/0/%0d",
                 i, mac_cnt[i], done_cnt[i], vecwe_cnt[i], M);
      end
    end
  endtask

  task automatic test_mid_reset();
    clear_counts();
    tick(1'b0, 1'b0, 1'b1);
    idle_ticks(200);
    #2 reset = 1'b1;
    #1 check_all_zero("reset_async_compute");
    model_reset();
    clear_counts();
    idle_ticks(3);
    reset = 1'b0;
    idle_ticks(10);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (mac_cnt[i] !== 0 || ybw_cnt[i] !== 0 || done_cnt[i] !== 0) begin
        errors++;
        $display("FAIL post_reset_quiet PIPE%0d got mac_en=%0d ybuf_we=%0d done=%0d expected 0",
                 i, mac_cnt[i], ybw_cnt[i], done_cnt[i]);
      end
    end
    test_compute();
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 39);
      case (r)
        0:       tick(1'b1, 1'b0, 1'b0);
        1, 2:    tick(1'b0, 1'b1, 1'b0);
        3, 4, 5: tick(1'b0, 1'b0, 1'b1);
        6:       tick(1'b1, 1'b1, 1'b1);
        7:       tick(1'b0, 1'b1, 1'b1);
        default: tick(1'b0, 1'b0, 1'b0);
      endcase
    end
    idle_ticks(MM + M + 10);
  endtask

  initial begin
    model_reset();
    clear_counts();
    test_reset();
    test_load();
    test_compute();
    test_priority();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
